// File: rtl/ring_decoder.sv
// Receive-side checker for a one-hot ring sequence: decodes the position,
// tracks lock on correct advances, and reports/counts one-hot and sequence errors.
module ring_decoder #(
   parameter int WIDTH      = 4,
   parameter int LOCK_COUNT = 4,
   parameter int CNT_W      = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   input  logic [WIDTH-1:0]         ring_in,
   output logic [$clog2(WIDTH)-1:0] idx,
   output logic                     idx_valid,
   output logic                     locked,
   output logic                     err_onehot,
   output logic                     err_seq,
   output logic [CNT_W-1:0]         wrap_cnt,
   output logic [CNT_W-1:0]         err_cnt
);

   localparam int IDX_W = $clog2(WIDTH);
   localparam int GC_W  = $clog2(LOCK_COUNT + 1);

   localparam logic [1:0] HUNT   = 2'd0;
   localparam logic [1:0] SYNC   = 2'd1;
   localparam logic [1:0] LOCKED = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] prev_q, prev_d;
   logic [GC_W-1:0]  good_cnt_q, good_cnt_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             err_onehot_q, err_onehot_d;
   logic             err_seq_q, err_seq_d;
   logic [CNT_W-1:0] wrap_cnt_q, wrap_cnt_d;
   logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

   logic             is_onehot;
   logic             is_match;
   logic             is_wrap;
   logic [WIDTH-1:0] expected;
   logic [IDX_W-1:0] sample_idx;
   logic [GC_W-1:0]  good_cnt_inc;

   // Clearing the lowest set bit leaves zero only for a single-bit value.
   always_comb begin
      is_onehot    = (ring_in != '0) && ((ring_in & (ring_in - 1'b1)) == '0);
      expected     = {prev_q[WIDTH-2:0], prev_q[WIDTH-1]};
      is_match     = is_onehot && (ring_in == expected);
      is_wrap      = prev_q[WIDTH-1] && ring_in[0];
      good_cnt_inc = good_cnt_q + GC_W'(1);
      sample_idx   = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (ring_in[i]) begin
            sample_idx = IDX_W'(i);
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      prev_d       = prev_q;
      good_cnt_d   = good_cnt_q;
      idx_d        = idx_q;
      err_onehot_d = 1'b0;
      err_seq_d    = 1'b0;
      wrap_cnt_d   = wrap_cnt_q;
      err_cnt_d    = err_cnt_q;

      if (in_valid) begin
         if (!is_onehot) begin
            err_onehot_d = 1'b1;
            state_d      = HUNT;
         end else begin
            idx_d  = sample_idx;
            prev_d = ring_in;
            case (state_q)
               HUNT: begin
                  good_cnt_d = '0;
                  state_d    = SYNC;
               end
               SYNC: begin
                  if (is_match) begin
                     good_cnt_d = good_cnt_inc;
                     if (good_cnt_inc == GC_W'(LOCK_COUNT)) begin
                        state_d = LOCKED;
                        if (is_wrap) begin
                           wrap_cnt_d = wrap_cnt_q + CNT_W'(1);
                        end
                     end
                  end else begin
                     err_seq_d  = 1'b1;
                     good_cnt_d = '0;
                  end
               end
               LOCKED: begin
                  if (is_match) begin
                     if (is_wrap) begin
                        wrap_cnt_d = wrap_cnt_q + CNT_W'(1);
                     end
                  end else begin
                     err_seq_d  = 1'b1;
                     good_cnt_d = '0;
                     state_d    = SYNC;
                  end
               end
               default: begin
                  state_d = HUNT;
               end
            endcase
         end

         if ((err_onehot_d || err_seq_d) && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= HUNT;
         prev_q       <= '0;
         good_cnt_q   <= '0;
         idx_q        <= '0;
         err_onehot_q <= 1'b0;
         err_seq_q    <= 1'b0;
         wrap_cnt_q   <= '0;
         err_cnt_q    <= '0;
      end else begin
         state_q      <= state_d;
         prev_q       <= prev_d;
         good_cnt_q   <= good_cnt_d;
         idx_q        <= idx_d;
         err_onehot_q <= err_onehot_d;
         err_seq_q    <= err_seq_d;
         wrap_cnt_q   <= wrap_cnt_d;
         err_cnt_q    <= err_cnt_d;
      end
   end

   assign idx        = idx_q;
   assign locked     = (state_q == LOCKED);
   assign idx_valid  = (state_q == LOCKED);
   assign err_onehot = err_onehot_q;
   assign err_seq    = err_seq_q;
   assign wrap_cnt   = wrap_cnt_q;
   assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_ring_decoder.sv
// Directed bench for ring_decoder: a position-based reference model checked
// every cycle, plus hand-computed expectations at key points.
module tb_ring_decoder;

   localparam int WIDTH      = 4;
   localparam int LOCK_COUNT = 4;
   localparam int CNT_W      = 8;
   localparam int CNT_MAX    = (1 << CNT_W) - 1;

   logic             clk;
   logic             rst;
   logic             in_valid;
   logic [WIDTH-1:0] ring_in;
   logic [1:0]       idx;
   logic             idx_valid;
   logic             locked;
   logic             err_onehot;
   logic             err_seq;
   logic [CNT_W-1:0] wrap_cnt;
   logic [CNT_W-1:0] err_cnt;

   int n_checks = 0;
   int n_pass   = 0;

   ring_decoder #(.WIDTH(WIDTH), .LOCK_COUNT(LOCK_COUNT), .CNT_W(CNT_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .ring_in    (ring_in),
      .idx        (idx),
      .idx_valid  (idx_valid),
      .locked     (locked),
      .err_onehot (err_onehot),
      .err_seq    (err_seq),
      .wrap_cnt   (wrap_cnt),
      .err_cnt    (err_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model works on ring positions (0..WIDTH-1) rather than one-hot vectors.
   typedef struct {
      int  mode;
      int  pos;
      int  good;
      int  idx;
      bit  eoh;
      bit  eseq;
      int  wraps;
      int  errs;
   } model_t;

   model_t m;

   function automatic model_t model_step(model_t cur, logic v, logic [WIDTH-1:0] r);
      model_t n = cur;
      int     p = 0;
      n.eoh  = 0;
      n.eseq = 0;
      if (v) begin
         if ($countones(r) != 1) begin
            n.eoh  = 1;
            n.mode = 0;
         end else begin
            for (int i = 0; i < WIDTH; i++) if (r[i]) p = i;
            n.idx = p;
            if (cur.mode == 0) begin
               n.mode = 1;
               n.good = 0;
            end else if (p == (cur.pos + 1) % WIDTH) begin
               if (cur.mode == 1) n.good = cur.good + 1;
               if (cur.mode == 2 || n.good == LOCK_COUNT) begin
                  n.mode = 2;
                  if (p == 0) n.wraps = (cur.wraps + 1) % (CNT_MAX + 1);
               end
            end else begin
               n.eseq = 1;
               n.good = 0;
               n.mode = 1;
            end
            n.pos = p;
         end
         if ((n.eoh || n.eseq) && n.errs < CNT_MAX) n.errs = cur.errs + 1;
      end
      return n;
   endfunction

   always @(posedge clk or negedge rst) begin
      if (!rst) m <= '{default: 0};
      else      m <= model_step(m, in_valid, ring_in);
   end

   task automatic check_output(input string name, input int actual, input int expected);
      n_checks++;
      if (actual == expected) n_pass++;
      else $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
   endtask

   // Every cycle, compare all outputs against the model away from the active edge.
   always @(negedge clk) begin
      check_output("cyc_idx",        int'(idx),        m.idx);
      check_output("cyc_locked",     int'(locked),     int'(m.mode == 2));
      check_output("cyc_idx_valid",  int'(idx_valid),  int'(m.mode == 2));
      check_output("cyc_err_onehot", int'(err_onehot), int'(m.eoh));
      check_output("cyc_err_seq",    int'(err_seq),    int'(m.eseq));
      check_output("cyc_wrap_cnt",   int'(wrap_cnt),   m.wraps);
      check_output("cyc_err_cnt",    int'(err_cnt),    m.errs);
   end

   task automatic apply_stimulus(input logic v, input logic [WIDTH-1:0] r);
      @(negedge clk);
      in_valid = v;
      ring_in  = r;
      @(posedge clk);
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      check_output({tag, "_idx"},    int'(idx),       0);
      check_output({tag, "_locked"}, int'(locked),    0);
      check_output({tag, "_ivalid"}, int'(idx_valid), 0);
      check_output({tag, "_eoh"},    int'(err_onehot), 0);
      check_output({tag, "_eseq"},   int'(err_seq),   0);
      check_output({tag, "_wrap"},   int'(wrap_cnt),  0);
      check_output({tag, "_err"},    int'(err_cnt),   0);
   endtask

   initial begin
      rst      = 1'b0;
      in_valid = 1'b0;
      ring_in  = '0;
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      rst = 1'b1;
      repeat (3) apply_stimulus(1'b0, 4'b0000);
      check_all_zero("idle");

      // Clean ring: the 5th sample (8->1) both locks and counts a wrap.
      apply_stimulus(1'b1, 4'b0001);
      apply_stimulus(1'b1, 4'b0010);
      apply_stimulus(1'b1, 4'b0100);
      apply_stimulus(1'b1, 4'b1000);
      check_output("pre_lock", int'(locked), 0);
      check_output("pre_lock_idx", int'(idx), 3);
      apply_stimulus(1'b1, 4'b0001);
      check_output("lock", int'(locked), 1);
      check_output("lock_idx", int'(idx), 0);
      check_output("lock_wrap", int'(wrap_cnt), 1);
      apply_stimulus(1'b1, 4'b0010);
      apply_stimulus(1'b1, 4'b0100);
      apply_stimulus(1'b1, 4'b1000);
      apply_stimulus(1'b1, 4'b0001);
      check_output("wrap2", int'(wrap_cnt), 2);
      check_output("clean_err", int'(err_cnt), 0);

      // One-hot error while locked.
      apply_stimulus(1'b1, 4'b0110);
      check_output("oh_pulse", int'(err_onehot), 1);
      check_output("oh_locked", int'(locked), 0);
      check_output("oh_idx_hold", int'(idx), 0);
      check_output("oh_err_cnt", int'(err_cnt), 1);
      apply_stimulus(1'b1, 4'b0001);
      check_output("oh_pulse_end", int'(err_onehot), 0);
      apply_stimulus(1'b1, 4'b0010);
      apply_stimulus(1'b1, 4'b0100);
      apply_stimulus(1'b1, 4'b1000);
      check_output("oh_not_yet", int'(locked), 0);
      apply_stimulus(1'b1, 4'b0001);
      check_output("oh_relock", int'(locked), 1);
      check_output("oh_relock_wrap", int'(wrap_cnt), 3);

      // Sequence skip 2 -> 8.
      apply_stimulus(1'b1, 4'b0010);
      apply_stimulus(1'b1, 4'b1000);
      check_output("skip_pulse", int'(err_seq), 1);
      check_output("skip_locked", int'(locked), 0);
      check_output("skip_idx", int'(idx), 3);
      check_output("skip_err_cnt", int'(err_cnt), 2);
      apply_stimulus(1'b1, 4'b0001);
      apply_stimulus(1'b1, 4'b0010);
      apply_stimulus(1'b1, 4'b0100);
      check_output("skip_not_yet", int'(locked), 0);
      apply_stimulus(1'b1, 4'b1000);
      check_output("skip_relock", int'(locked), 1);
      check_output("skip_wrap_hold", int'(wrap_cnt), 3);

      // Stall, then repeat the last value.
      repeat (10) apply_stimulus(1'b0, 4'b0001);
      check_output("stall_locked", int'(locked), 1);
      check_output("stall_idx", int'(idx), 3);
      check_output("stall_err_cnt", int'(err_cnt), 2);
      apply_stimulus(1'b1, 4'b1000);
      check_output("repeat_pulse", int'(err_seq), 1);
      check_output("repeat_locked", int'(locked), 0);
      check_output("repeat_err_cnt", int'(err_cnt), 3);

      // Relock, then async reset between edges.
      apply_stimulus(1'b1, 4'b0001);
      apply_stimulus(1'b1, 4'b0010);
      apply_stimulus(1'b1, 4'b0100);
      apply_stimulus(1'b1, 4'b1000);
      check_output("pre_rst_locked", int'(locked), 1);
      #2 rst = 1'b0;
      #1 check_all_zero("async_rst");
      @(negedge clk);
      rst = 1'b1;

      // Saturation with back-to-back one-hot errors.
      for (int i = 0; i < 300; i++) apply_stimulus(1'b1, 4'b0000);
      check_output("sat_err_cnt", int'(err_cnt), CNT_MAX);
      check_output("sat_pulse", int'(err_onehot), 1);
      apply_stimulus(1'b1, 4'b0011);
      check_output("sat_hold", int'(err_cnt), CNT_MAX);
      apply_stimulus(1'b0, 4'b0000);
      check_output("sat_pulse_end", int'(err_onehot), 0);
      @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/ring_decoder.md
Name: ring_decoder

Overview:
Receive-side checker and decoder for the one-hot ring sequence produced by the team's ring counters.
- Samples a WIDTH-bit one-hot ring value and converts it to a binary index.
- Verifies that the ring advances one position per valid sample.
- Acquires lock after a run of correct advances.
- Reports one-hot errors and sequence errors, and counts wraps and errors.
- Sits downstream of a ring counter, in a monitor or clock-domain-local status path.

Parameters:
WIDTH, 4, number of ring positions (one-hot width), must be >= 2
LOCK_COUNT, 4, consecutive correct advances required to assert locked, must be >= 1
CNT_W, 8, width of wrap_cnt and err_cnt

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous reset, active-low (0 = reset)
in_valid  input  1  ring_in is sampled on this clock edge
ring_in  input  WIDTH  one-hot ring value (bit 0 = position 0)
idx  output  $clog2(WIDTH)  binary index of last valid one-hot sample
idx_valid  output  1  high while in LOCKED
locked  output  1  high while in LOCKED
err_onehot  output  1  one-cycle pulse: sampled value not one-hot
err_seq  output  1  one-cycle pulse: one-hot sample is not the expected next position
wrap_cnt  output  CNT_W  count of MSB->bit0 wraps while LOCKED, modulo 2^CNT_W
err_cnt  output  CNT_W  total error events, saturating at all-ones

Behaviour:
- rst low, at any time including mid-operation, immediately clears state and outputs:
  - state=HUNT, internal prev and good_cnt cleared
  - idx=0, idx_valid=0, locked=0, err_onehot=0, err_seq=0, wrap_cnt=0, err_cnt=0
- All outputs are registered. A sample taken on edge k is reflected after edge k (1-cycle latency).
- in_valid=0: full stall. State, prev, good_cnt, idx and counters hold. Error pulses are 0.
- One-hot check: the sample is valid one-hot when exactly one bit is set. Zero bits or more than one bit is a one-hot error.
- Expected next value = rotate-left of prev, with bit WIDTH-1 going to bit 0 (4-bit ring: 1->2->4->8->1).
- States:
  - HUNT:
    - valid one-hot sample -> store as prev, good_cnt=0, go to SYNC.
    - one-hot error -> pulse err_onehot, stay in HUNT.
  - SYNC:
    - sample == expected -> prev=sample, good_cnt+1.
    - When good_cnt reaches LOCK_COUNT -> go to LOCKED. locked and idx_valid are high after that same edge.
    - one-hot sample != expected, including a repeat of prev -> pulse err_seq, prev=sample, good_cnt=0, stay in SYNC.
    - one-hot error -> pulse err_onehot, go to HUNT.
  - LOCKED:
    - sample == expected -> prev=sample. If prev was bit WIDTH-1 and sample is bit 0, wrap_cnt+1.
    - one-hot sample != expected -> pulse err_seq, prev=sample, good_cnt=0, go to SYNC. locked drops after this edge.
    - one-hot error -> pulse err_onehot, go to HUNT.
- idx updates on every valid one-hot sample in any state. It holds its value on one-hot errors.
- err_cnt increments by 1 per err_onehot or err_seq event. The two never fire on the same edge. It saturates at all-ones.
- wrap_cnt increments only in LOCKED, including the edge that enters LOCKED if that advance is a wrap. It wraps modulo 2^CNT_W.
- Error pulses last exactly one cycle per offending sample. Back-to-back bad samples give back-to-back pulses.

Test Plan:
- Reset: hold rst=0, toggle clk -> all outputs 0. Release rst; with in_valid=0 all outputs stay 0.
- Clean ring: in_valid=1, ring_in=1,2,4,8,1,2,... each cycle -> locked=1 after 5th sample (4 advances). idx follows 0,1,2,3,0. wrap_cnt=1 after the first 8->1 while locked, then +1 every 4 samples. err_cnt=0.
- One-hot error: while LOCKED apply ring_in=4'b0110 -> err_onehot pulses 1 cycle, locked=0, idx holds, err_cnt=1. Next sample 4'b0001 -> SYNC. After 4 further correct advances, locked=1.
- Sequence skip: while LOCKED apply 2 then 8 -> err_seq pulses, locked=0, idx=3, err_cnt+1. Continuing 1,2,4,8 relocks after 4 advances.
- Stall and repeat: while LOCKED hold in_valid=0 for 10 cycles -> outputs unchanged, no pulses. Then repeat the last value -> err_seq.
- Async reset and saturation: assert rst=0 between clock edges while LOCKED -> all outputs 0 immediately. Drive 300 alternating 0/0/... samples -> err_cnt saturates at 255.
